dsi_lane_scheduler: RTL and testbench

- Shares one DSI lane byte interface between N_SRC packet FIFOs, e.g. an LP command FIFO and an HS pixel FIFO.
- Picks one non-empty FIFO by round-robin and frames its contents as one lane transaction (start, data stream, fin).
- Enforces a programmable packet-to-packet gap before the next grant.
- Sits between the packet assembler FIFOs and the lane serializer.

---
 rtl/dsi_lane_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_dsi_lane_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_lane_scheduler.sv
// Round-robin arbiter framing one of N_SRC packet FIFOs onto a DSI lane.
// Each grant emits start, a byte stream, fin, then a programmable gap.
module dsi_lane_scheduler #(
  parameter int N_SRC       = 2,
  parameter int GAP_W       = 16,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_empty,
  input  logic [N_SRC-1:0]   src_mode_lp,
  input  logic [N_SRC-1:0]   src_en,
  output logic [N_SRC-1:0]   src_read,
  output logic [7:0]         lane_data,
  output logic               lane_mode_lp,
  output logic               lane_start_rqst,
  output logic               lane_fin_rqst,
  input  logic               lane_data_rqst,
  input  logic [GAP_W-1:0]   p2p_gap,
  output logic [2:0]         grant_id,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       data_q, data_d;
  logic             mode_q, mode_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] g_oh;
  logic [N_SRC-1:0] rd;
  logic             hi_vld, lo_vld, pick_vld;
  logic [2:0]       hi, lo, pick;
  logic [2:0]       ptr_nxt;
  logic [7:0]       head, head_rev, head_lane;
  logic             g_empty, g_mode;
  logic             start, fin;

  assign elig = src_en & ~src_empty;

  // Rotating priority: lowest eligible index at or above ptr, else wrap.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi     = '0;
    lo     = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (elig[k]) begin
        if (3'(k) >= ptr_q) begin
          hi_vld = 1'b1;
          hi     = 3'(k);
        end else begin
          lo_vld = 1'b1;
          lo     = 3'(k);
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick     = hi_vld ? hi : lo;
  end

  always_comb begin
    head    = '0;
    g_empty = 1'b0;
    g_mode  = 1'b0;
    g_oh    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant_q == 3'(k)) begin
        head    = src_data[8*k +: 8];
        g_empty = src_empty[k];
        g_mode  = src_mode_lp[k];
        g_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    head_rev = '0;
    for (int i = 0; i < 8; i++) begin
      head_rev[i] = head[7-i];
    end
    head_lane = BIT_REVERSE ? head_rev : head;
  end

  assign ptr_nxt = (grant_q == 3'(N_SRC - 1)) ? 3'd0
                                              : grant_q + 3'd1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    gap_d   = gap_q;
    rd      = '0;
    start   = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = START;
        end
      end
      START: begin
        if (g_empty) begin
          state_d = IDLE;
        end else if (lane_data_rqst) begin
          start   = 1'b1;
          rd      = g_oh;
          data_d  = head_lane;
          mode_d  = g_mode;
          ptr_d   = ptr_nxt;
          state_d = SEND;
        end
      end
      SEND: begin
        if (lane_data_rqst) begin
          if (!g_empty) begin
            rd     = g_oh;
            data_d = head_lane;
          end else begin
            fin     = 1'b1;
            gap_d   = p2p_gap;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          mode_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Keep FIFOs and lane untouched during reset.
    if (rst) begin
      rd    = '0;
      start = 1'b0;
      fin   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      gap_q   <= gap_d;
    end
  end

  assign src_read        = rd;
  assign lane_data       = data_q;
  assign lane_mode_lp    = mode_q;
  assign lane_start_rqst = start;
  assign lane_fin_rqst   = fin;
  assign grant_id        = grant_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_dsi_lane_scheduler.sv
// Directed bench for dsi_lane_scheduler: queue-backed FIFOs and
// hand-computed expectations for framing, arbitration, stalls and reset.
module tb_dsi_lane_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src_data;
  logic [1:0]  src_empty, src_mode_lp, src_en, src_read;
  logic [7:0]  lane_data;
  logic        lane_mode_lp, lane_start_rqst, lane_fin_rqst;
  logic        lane_data_rqst;
  logic [15:0] p2p_gap;
  logic [2:0]  grant_id;
  logic        busy;

  logic [15:0] d2_data;
  logic [1:0]  d2_empty, d2_mode, d2_read;
  logic [7:0]  d2_lane;
  logic        d2_mode_out, d2_start, d2_fin, d2_rqst;
  logic [2:0]  d2_gid;
  logic        d2_busy;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [1:0]  rd;
  int          n_vec, n_err, cyc;
  int          n, t_fin;
  logic        rd0_seen;
  logic [2:0]  g_seen;

  bit          t3_rq [0:8] = '{1, 0, 0, 1, 1, 0, 1, 0, 1};
  bit          t3_rd [0:8] = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
  bit          t3_st [0:8] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
  bit          t3_fn [0:8] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
  logic [7:0]  t3_ln [0:8] = '{8'h00, 8'h88, 8'h88, 8'h88, 8'h44,
                               8'hCC, 8'hCC, 8'h22, 8'h22};

  always #5 clk = ~clk;

  dsi_lane_scheduler #(
    .N_SRC      (2),
    .GAP_W      (16),
    .BIT_REVERSE(1'b1)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .src_data       (src_data),
    .src_empty      (src_empty),
    .src_mode_lp    (src_mode_lp),
    .src_en         (src_en),
    .src_read       (src_read),
    .lane_data      (lane_data),
    .lane_mode_lp   (lane_mode_lp),
    .lane_start_rqst(lane_start_rqst),
    .lane_fin_rqst  (lane_fin_rqst),
    .lane_data_rqst (lane_data_rqst),
    .p2p_gap        (p2p_gap),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  dsi_lane_scheduler #(
    .N_SRC      (2),
    .GAP_W      (16),
    .BIT_REVERSE(1'b0)
  ) u_dut_nr (
    .clk            (clk),
    .rst            (rst),
    .src_data       (d2_data),
    .src_empty      (d2_empty),
    .src_mode_lp    (d2_mode),
    .src_en         (2'b11),
    .src_read       (d2_read),
    .lane_data      (d2_lane),
    .lane_mode_lp   (d2_mode_out),
    .lane_start_rqst(d2_start),
    .lane_fin_rqst  (d2_fin),
    .lane_data_rqst (d2_rqst),
    .p2p_gap        (16'd0),
    .grant_id       (d2_gid),
    .busy           (d2_busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    src_empty[0]  = (q0.size() == 0);
    src_empty[1]  = (q1.size() == 0);
    src_data[7:0] = (q0.size() != 0) ? q0[0] : 8'h00;
    src_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  task automatic tick();
    #1;
    rd = src_read;
    @(posedge clk);
    #1;
    if (rd[0] && q0.size() != 0) void'(q0.pop_front());
    if (rd[1] && q1.size() != 0) void'(q1.pop_front());
    refresh();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    refresh();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    src_en = 2'b11;
    src_mode_lp = 2'b00;
    lane_data_rqst = 1'b1;
    p2p_gap = 16'd0;
    d2_data = 16'h003C;
    d2_empty = 2'b11;
    d2_mode = 2'b00;
    d2_rqst = 1'b1;
    refresh();
    tick();
    tick();

    check("rst_busy", busy, 0);
    check("rst_lane", lane_data, 8'h00);
    check("rst_mode", lane_mode_lp, 0);
    check("rst_start", lane_start_rqst, 0);
    check("rst_fin", lane_fin_rqst, 0);
    check("rst_read", src_read, 2'b00);
    check("rst_gid", grant_id, 0);
    rst = 1'b0;
    #1;

    // Three-byte LP packet with a gap of 4.
    src_mode_lp = 2'b01;
    p2p_gap = 16'd4;
    q0.push_back(8'h01);
    q0.push_back(8'h80);
    q0.push_back(8'hFF);
    refresh();
    #1;
    check("t1_no_pulse_idle", lane_start_rqst, 0);
    tick();
    check("t1_start", lane_start_rqst, 1);
    check("t1_gid", grant_id, 0);
    check("t1_rd_start", src_read, 2'b01);
    tick();
    check("t1_b0", lane_data, 8'h80);
    check("t1_mode", lane_mode_lp, 1);
    tick();
    check("t1_b1", lane_data, 8'h01);
    check("t1_rd_b1", src_read, 2'b01);
    tick();
    check("t1_b2", lane_data, 8'hFF);
    check("t1_fin", lane_fin_rqst, 1);
    check("t1_rd_fin", src_read, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_gap_busy", busy, 1);
    end
    tick();
    check("t1_idle", busy, 0);
    check("t1_mode_clr", lane_mode_lp, 0);

    // Alternating grants with gap 0.
    do_reset();
    src_en = 2'b11;
    src_mode_lp = 2'b00;
    p2p_gap = 16'd0;
    q0.push_back(8'hA0);
    q0.push_back(8'hA1);
    q1.push_back(8'hB0);
    q1.push_back(8'hB1);
    refresh();
    #1;
    t_fin = 0;
    for (int p = 0; p < 4; p++) begin
      n = 0;
      while (!lane_start_rqst && n < 20) begin
        tick();
        n++;
      end
      check("t2_start_seen", n < 20, 1);
      check("t2_gid", grant_id, p % 2);
      if (p > 0) check("t2_spacing", cyc - t_fin, 3);
      n = 0;
      while (!lane_fin_rqst && n < 20) begin
        tick();
        n++;
      end
      check("t2_fin_seen", n < 20, 1);
      t_fin = cyc;
      tick();
      if (p % 2 == 0) begin
        q0.push_back(8'hA2);
        q0.push_back(8'hA3);
      end else begin
        q1.push_back(8'hB2);
        q1.push_back(8'hB3);
      end
      refresh();
      #1;
    end

    // Request stalls during a four-byte packet.
    do_reset();
    src_en = 2'b01;
    p2p_gap = 16'd1;
    q0.push_back(8'h11);
    q0.push_back(8'h22);
    q0.push_back(8'h33);
    q0.push_back(8'h44);
    refresh();
    #1;
    tick();
    for (int i = 0; i < 9; i++) begin
      lane_data_rqst = t3_rq[i];
      #1;
      check("t3_read", src_read, {1'b0, t3_rd[i]});
      check("t3_start", lane_start_rqst, t3_st[i]);
      check("t3_fin", lane_fin_rqst, t3_fn[i]);
      check("t3_lane", lane_data, t3_ln[i]);
      tick();
    end
    check("t3_gap_busy", busy, 1);
    check("t3_gap_fin", lane_fin_rqst, 0);
    lane_data_rqst = 1'b1;

    // Only source 1 enabled.
    do_reset();
    src_en = 2'b10;
    p2p_gap = 16'd0;
    q0.push_back(8'hAA);
    q0.push_back(8'hBB);
    q1.push_back(8'h1E);
    refresh();
    #1;
    rd0_seen = 1'b0;
    g_seen = 3'd7;
    for (int i = 0; i < 8; i++) begin
      rd0_seen = rd0_seen | src_read[0];
      if (lane_start_rqst) g_seen = grant_id;
      tick();
    end
    check("t4_rd0", rd0_seen, 0);
    check("t4_gid", g_seen, 1);
    check("t4_q0_kept", q0.size(), 2);
    check("t4_lane", lane_data, 8'h78);
    check("t4_idle", busy, 0);

    // Reset mid-packet.
    do_reset();
    src_en = 2'b11;
    src_mode_lp = 2'b01;
    q0.push_back(8'h01);
    q0.push_back(8'h02);
    q0.push_back(8'h03);
    q0.push_back(8'h04);
    q0.push_back(8'h05);
    q1.push_back(8'h77);
    refresh();
    #1;
    tick();
    tick();
    tick();
    check("t5_q0_mid", q0.size(), 3);
    check("t5_lane_mid", lane_data, 8'h40);
    check("t5_mode_mid", lane_mode_lp, 1);
    rst = 1'b1;
    #1;
    check("t5_rd_in_rst", src_read, 2'b00);
    check("t5_fin_in_rst", lane_fin_rqst, 0);
    tick();
    check("t5_busy", busy, 0);
    check("t5_lane", lane_data, 8'h00);
    check("t5_mode", lane_mode_lp, 0);
    check("t5_gid", grant_id, 0);
    check("t5_start", lane_start_rqst, 0);
    check("t5_fin", lane_fin_rqst, 0);
    check("t5_read", src_read, 2'b00);
    check("t5_q0_kept", q0.size(), 3);
    rst = 1'b0;
    #1;
    tick();
    check("t5_regrant_start", lane_start_rqst, 1);
    check("t5_regrant_gid", grant_id, 0);

    // Straight byte order, HS mode.
    d2_empty = 2'b10;
    #1;
    tick();
    check("t6_start", d2_start, 1);
    check("t6_read", d2_read, 2'b01);
    tick();
    d2_empty = 2'b11;
    #1;
    check("t6_lane", d2_lane, 8'h3C);
    check("t6_mode", d2_mode_out, 0);
    check("t6_fin", d2_fin, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
